// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_resp
// Brief    : Responder end of the sram_if data-memory protocol. Byte-masked
//            word writes, 1-cycle registered word reads, out-of-range
//            detection with a sticky first-error address, and per-type
//            access counters.
// Options  : DATA_SRAM_BYPASS_EN - when defined, a same-cycle read and write
//            to the same word returns the mask-merged (write-first) word;
//            otherwise the pre-write (read-first) word is returned.
// Revision : 1.0 - initial release
// ============================================================================
module data_sram_resp #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 16384,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1C00_0000,
    parameter int                    CNT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sram_rd_en,
    input  logic [ADDR_WIDTH-1:0]   sram_rd_addr,
    output logic [DATA_WIDTH-1:0]   sram_rd_data,
    input  logic                    sram_wr_en,
    input  logic [ADDR_WIDTH-1:0]   sram_wr_addr,
    input  logic [DATA_WIDTH-1:0]   sram_wr_data,
    input  logic [DATA_WIDTH/8-1:0] sram_wr_mask,
    output logic                    acc_err,
    output logic [ADDR_WIDTH-1:0]   acc_err_addr,
    output logic [CNT_WIDTH-1:0]    rd_cnt,
    output logic [CNT_WIDTH-1:0]    wr_cnt
);

    localparam int                    c_NUM_BYTES = DATA_WIDTH / 8;
    localparam int                    c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] c_DEPTH     = ADDR_WIDTH'(DEPTH_WORDS);

    // Storage array; contents are deliberately not reset.
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH_WORDS-1];

    logic [ADDR_WIDTH-1:0] w_rd_off;
    logic [ADDR_WIDTH-1:0] w_wr_off;
    logic                  w_rd_in;
    logic                  w_wr_in;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic                  w_rd_do;
    logic                  w_wr_do;
    logic                  w_rd_oor;
    logic                  w_wr_oor;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [DATA_WIDTH-1:0] r_rd_data_q,    w_rd_data_d;
    logic                  r_acc_err_q,    w_acc_err_d;
    logic [ADDR_WIDTH-1:0] r_err_addr_q,   w_err_addr_d;
    logic [CNT_WIDTH-1:0]  r_rd_cnt_q,     w_rd_cnt_d;
    logic [CNT_WIDTH-1:0]  r_wr_cnt_q,     w_wr_cnt_d;

    // Address decode: unsigned offset from the base; underflow wraps to a
    // large offset, but the explicit >= BASE_ADDR test rejects it anyway.
    always_comb begin
        w_rd_off = sram_rd_addr - BASE_ADDR;
        w_wr_off = sram_wr_addr - BASE_ADDR;
        w_rd_in  = (sram_rd_addr >= BASE_ADDR) && ((w_rd_off >> 2) < c_DEPTH);
        w_wr_in  = (sram_wr_addr >= BASE_ADDR) && ((w_wr_off >> 2) < c_DEPTH);
        w_rd_idx = w_rd_off[c_IDX_W+1:2];
        w_wr_idx = w_wr_off[c_IDX_W+1:2];
        w_rd_do  = sram_rd_en && w_rd_in;
        w_wr_do  = sram_wr_en && w_wr_in && (sram_wr_mask != '0);
        w_rd_oor = sram_rd_en && !w_rd_in;
        w_wr_oor = sram_wr_en && !w_wr_in;
    end

    // Word presented to the read register, optionally merged with a
    // colliding same-cycle write.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
`ifdef DATA_SRAM_BYPASS_EN
        if (w_wr_do && (w_wr_idx == w_rd_idx)) begin
            for (int b = 0; b < c_NUM_BYTES; b++) begin
                if (sram_wr_mask[b]) begin
                    w_rd_word[8*b +: 8] = sram_wr_data[8*b +: 8];
                end
            end
        end
`endif
    end

    // Next-state for read data, sticky error capture and counters.
    always_comb begin
        w_rd_data_d  = r_rd_data_q;
        w_acc_err_d  = r_acc_err_q;
        w_err_addr_d = r_err_addr_q;
        w_rd_cnt_d   = r_rd_cnt_q;
        w_wr_cnt_d   = r_wr_cnt_q;

        if (sram_rd_en) begin
            w_rd_data_d = w_rd_do ? w_rd_word : '0;
        end

        // Only the first error is kept; the write wins a same-cycle tie.
        if (!r_acc_err_q) begin
            if (w_wr_oor) begin
                w_acc_err_d  = 1'b1;
                w_err_addr_d = sram_wr_addr;
            end else if (w_rd_oor) begin
                w_acc_err_d  = 1'b1;
                w_err_addr_d = sram_rd_addr;
            end
        end

        if (w_rd_do) begin
            w_rd_cnt_d = r_rd_cnt_q + CNT_WIDTH'(1);
        end
        if (w_wr_do) begin
            w_wr_cnt_d = r_wr_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Control/status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data_q  <= '0;
            r_acc_err_q  <= 1'b0;
            r_err_addr_q <= '0;
            r_rd_cnt_q   <= '0;
            r_wr_cnt_q   <= '0;
        end else begin
            r_rd_data_q  <= w_rd_data_d;
            r_acc_err_q  <= w_acc_err_d;
            r_err_addr_q <= w_err_addr_d;
            r_rd_cnt_q   <= w_rd_cnt_d;
            r_wr_cnt_q   <= w_wr_cnt_d;
        end
    end

    // Byte-masked array write; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_do) begin
            for (int b = 0; b < c_NUM_BYTES; b++) begin
                if (sram_wr_mask[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= sram_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign sram_rd_data = r_rd_data_q;
    assign acc_err      = r_acc_err_q;
    assign acc_err_addr = r_err_addr_q;
    assign rd_cnt       = r_rd_cnt_q;
    assign wr_cnt       = r_wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_resp
// Brief    : Directed self-checking bench for data_sram_resp. Expected read
//            words are queued when a read is issued and compared one cycle
//            later; status outputs are compared against constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_resp;

    localparam logic [31:0] c_B   = 32'h1C00_0000;
    localparam logic [31:0] c_OOR = 32'h1C00_0000 + 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_rd_en;
    logic [31:0] sram_rd_addr;
    logic [31:0] sram_rd_data;
    logic        sram_wr_en;
    logic [31:0] sram_wr_addr;
    logic [31:0] sram_wr_data;
    logic [3:0]  sram_wr_mask;
    logic        acc_err;
    logic [31:0] acc_err_addr;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] sb [$];

    data_sram_resp dut (
        .clk          (clk),
        .rst          (rst),
        .sram_rd_en   (sram_rd_en),
        .sram_rd_addr (sram_rd_addr),
        .sram_rd_data (sram_rd_data),
        .sram_wr_en   (sram_wr_en),
        .sram_wr_addr (sram_wr_addr),
        .sram_wr_data (sram_wr_data),
        .sram_wr_mask (sram_wr_mask),
        .acc_err      (acc_err),
        .acc_err_addr (acc_err_addr),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock; if a read was presented at the edge, compare its result.
    task automatic tick();
        logic pend;
        pend = sram_rd_en && !rst;
        @(posedge clk);
        #1;
        if (pend) begin
            if (sb.size() > 0) begin
                chk("rd_data", sram_rd_data, sb.pop_front());
            end else begin
                n_total++;
                $error("FAIL sb_empty: observed read with no expected entry");
            end
        end
    endtask

    task automatic idle();
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        sram_wr_mask = 4'h0;
    endtask

    task automatic status(input string tag, input logic [31:0] e_err,
                          input logic [31:0] e_addr, input logic [31:0] e_rc,
                          input logic [31:0] e_wc);
        chk({tag, ".acc_err"},      {31'b0, acc_err}, e_err);
        chk({tag, ".acc_err_addr"}, acc_err_addr,     e_addr);
        chk({tag, ".rd_cnt"},       rd_cnt,           e_rc);
        chk({tag, ".wr_cnt"},       wr_cnt,           e_wc);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        sram_rd_addr = '0;
        sram_wr_addr = '0;
        sram_wr_data = '0;
        tick();
        tick();
        chk("reset.rd_data", sram_rd_data, 32'h0);
        status("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // Full write then single-lane patch, then read back.
        sram_wr_en = 1; sram_wr_addr = c_B + 4; sram_wr_data = 32'hAABBCCDD; sram_wr_mask = 4'b1111;
        tick();
        sram_wr_data = 32'h0000_EE00; sram_wr_mask = 4'b0010;
        tick();
        idle();
        sram_rd_en = 1; sram_rd_addr = c_B + 4; sb.push_back(32'hAABBEEDD);
        tick();
        idle();
        status("patch", 0, 0, 1, 2);

        // Same-cycle read/write collision at B+8 (old contents zero).
        sram_wr_en = 1; sram_wr_addr = c_B + 8; sram_wr_data = 32'h0; sram_wr_mask = 4'b1111;
        tick();
        sram_wr_data = 32'h11223344;
        sram_rd_en = 1; sram_rd_addr = c_B + 8;
`ifdef DATA_SRAM_BYPASS_EN
        sb.push_back(32'h11223344);
`else
        sb.push_back(32'h0);
`endif
        tick();
        sram_wr_en = 0; sram_wr_mask = 4'h0;
        sb.push_back(32'h11223344);
        tick();
        idle();
        status("collide", 0, 0, 3, 4);

        // Simultaneous read and write to different words.
        sram_wr_en = 1; sram_wr_addr = c_B + 12; sram_wr_data = 32'h55667788; sram_wr_mask = 4'b1111;
        sram_rd_en = 1; sram_rd_addr = c_B + 4; sb.push_back(32'hAABBEEDD);
        tick();
        idle();
        sram_rd_en = 1; sram_rd_addr = c_B + 12; sb.push_back(32'h55667788);
        tick();
        idle();
        status("indep", 0, 0, 5, 5);

        // Underflow read, then past-the-end write: first address sticks.
        sram_rd_en = 1; sram_rd_addr = c_B - 4; sb.push_back(32'h0);
        tick();
        idle();
        status("err_rd", 1, c_B - 4, 5, 5);
        sram_wr_en = 1; sram_wr_addr = c_OOR; sram_wr_data = 32'hDEADBEEF; sram_wr_mask = 4'b1111;
        tick();
        idle();
        status("err_wr", 1, c_B - 4, 5, 5);
        chk("err_wr.rd_data_held", sram_rd_data, 32'h0);

        // Zero-mask write is a no-op.
        sram_wr_en = 1; sram_wr_addr = c_B; sram_wr_data = 32'hCAFEF00D; sram_wr_mask = 4'b1111;
        tick();
        sram_wr_data = 32'h0; sram_wr_mask = 4'b0000;
        tick();
        idle();
        status("mask0", 1, c_B - 4, 5, 6);
        sram_rd_en = 1; sram_rd_addr = c_B; sb.push_back(32'hCAFEF00D);
        tick();
        idle();

        // Read data holds while rd_en is low.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold", sram_rd_data, 32'hCAFEF00D);
        end

        // Reset with concurrent write and read: write dropped, data cleared.
        rst = 1; sram_wr_en = 1; sram_wr_addr = c_B; sram_wr_data = 32'h12345678; sram_wr_mask = 4'b1111;
        sram_rd_en = 1; sram_rd_addr = c_B;
        tick();
        rst = 0;
        idle();
        chk("rst_busy.rd_data", sram_rd_data, 32'h0);
        status("rst_busy", 0, 0, 0, 0);

        // Zero-mask in-range write raises no error after reset.
        sram_wr_en = 1; sram_wr_addr = c_B; sram_wr_data = 32'hFFFFFFFF; sram_wr_mask = 4'b0000;
        tick();
        idle();
        status("mask0_noerr", 0, 0, 0, 0);
        sram_rd_en = 1; sram_rd_addr = c_B; sb.push_back(32'hCAFEF00D);
        tick();
        idle();
        status("post_rst", 0, 0, 1, 0);

        // Both out of range in one cycle: write address is captured.
        sram_rd_en = 1; sram_rd_addr = c_B - 8; sb.push_back(32'h0);
        sram_wr_en = 1; sram_wr_addr = c_OOR + 4; sram_wr_data = 32'h0; sram_wr_mask = 4'b1111;
        tick();
        idle();
        status("both_oor", 1, c_OOR + 4, 1, 0);

        // Last in-range word is accepted.
        sram_wr_en = 1; sram_wr_addr = c_OOR - 4; sram_wr_data = 32'h0BADCAFE; sram_wr_mask = 4'b1111;
        tick();
        idle();
        sram_rd_en = 1; sram_rd_addr = c_OOR - 4; sb.push_back(32'h0BADCAFE);
        tick();
        idle();
        status("last_word", 1, c_OOR + 4, 2, 1);

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder (slave) end of the `sram_if` data-memory protocol.
- Serves byte-masked writes and word reads from the MEM stage, which issues word-aligned addresses.
- Sits below the MEM stage in the core top: the on-chip data RAM for simulation and FPGA builds.
- Adds a registered read port, out-of-range detection, an access-error flag and per-type access counters.

Parameters:
- ADDR_WIDTH, 32, byte address width (matches `ADDR_WIDTH).
- DATA_WIDTH, 32, word width (matches `DATA_WIDTH); NUM_BYTES = DATA_WIDTH/8.
- DEPTH_WORDS, 16384, number of words in the array; power of two.
- BASE_ADDR, 32'h1C00_0000, byte address of word 0.
- CNT_WIDTH, 32, width of the access counters.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- sram_rd_en  input  1  read request this cycle.
- sram_rd_addr  input  ADDR_WIDTH  read byte address; bits [1:0] ignored.
- sram_rd_data  output  DATA_WIDTH  read word, registered.
- sram_wr_en  input  1  write request this cycle.
- sram_wr_addr  input  ADDR_WIDTH  write byte address; bits [1:0] ignored.
- sram_wr_data  input  DATA_WIDTH  write data, already lane-shifted by the initiator.
- sram_wr_mask  input  NUM_BYTES  byte-lane enables; bit i covers data[8i+7:8i].
- acc_err  output  1  sticky flag: an access fell out of range.
- acc_err_addr  output  ADDR_WIDTH  byte address of the first out-of-range access.
- rd_cnt  output  CNT_WIDTH  count of accepted in-range reads.
- wr_cnt  output  CNT_WIDTH  count of accepted in-range writes with a nonzero mask.

Behaviour:
- Ports are the slave view of `sram_if` (`sram_if.s`). One clock; reset is synchronous and active-high; all state updates on posedge clk.
- Reset values: sram_rd_data=0, acc_err=0, acc_err_addr=0, rd_cnt=0, wr_cnt=0. Array contents are not reset.
- Index computation:
  - idx = (addr - BASE_ADDR) >> 2.
  - An address is in range iff addr >= BASE_ADDR and idx < DEPTH_WORDS. Subtraction is unsigned; underflow counts as out of range.
- Write:
  - Applies when wr_en=1, wr_addr is in range and mask != 0.
  - For each set mask bit, the array byte is replaced by the corresponding wr_data byte at the clock edge. Unmasked bytes are unchanged.
  - mask=0 with wr_en=1 is a no-op: wr_cnt is not incremented and no error is raised.
- Read:
  - rd_en=1 in cycle N puts the word at idx on sram_rd_data from cycle N+1; latency is 1.
  - rd_en=0 holds sram_rd_data at its previous value.
  - An out-of-range read loads sram_rd_data=0.
- Simultaneous read and write to the same idx in the same cycle: behaviour is set by the optional feature below.
  - Simultaneous read and write to different idx are independent.
- Error:
  - The first out-of-range access (read or write with en=1) sets acc_err=1 and captures its address into acc_err_addr.
  - If read and write are both out of range in the same cycle, the write address is captured.
  - Later errors do not overwrite; only rst clears the flag and address.
- Counters:
  - Increment by 1 on each accepted in-range access.
  - Wrap modulo 2^CNT_WIDTH without saturation.
  - A simultaneous read and write each increment their own counter.
- rst=1 in a cycle with rd_en/wr_en asserted:
  - The write is suppressed and the array is unchanged.
  - The read result is discarded: rd_data=0.
  - Counters and error are reset.

Optional Feature:
- Macro: DATA_SRAM_BYPASS_EN.
- Defined: write-first. For a same-cycle read and write to the same idx, sram_rd_data(N+1) = mask-merged word: new bytes where mask=1, old array bytes elsewhere.
- Undefined: read-first. sram_rd_data(N+1) = pre-write word; the array still updates.
- Counters and error logic are identical in both builds.

Test Plan:
- Reset, then read BASE_ADDR -> sram_rd_data=0 after rst; acc_err=0, rd_cnt=0, wr_cnt=0.
- Write BASE_ADDR+4 data 32'hAABBCCDD mask 4'b1111; next cycle write data 32'h0000_EE00 mask 4'b0010; then read -> 32'hAABBEEDD one cycle later; wr_cnt=2, rd_cnt=1.
- Same-cycle write 32'h11223344 mask 4'b1111 and read at BASE_ADDR+8 (old 32'h0) -> rd_data=32'h11223344 with DATA_SRAM_BYPASS_EN, 32'h0 without; a following read returns 32'h11223344 in both builds.
- Read BASE_ADDR-4, then write BASE_ADDR+DEPTH_WORDS*4 -> acc_err=1, acc_err_addr=BASE_ADDR-4 (not overwritten), rd_data=0, both counters unchanged.
- wr_en=1 with mask 4'b0000 at BASE_ADDR holding 32'hCAFEF00D -> word unchanged, wr_cnt unchanged, no error.
- Hold rd_en=0 after reading 32'hCAFEF00D for 5 cycles -> rd_data stays 32'hCAFEF00D; assert rst with a concurrent write -> rd_data=0, and a later read shows the array was unchanged.
